// File: rtl/mvb_tx_sequencer_if.sv
// Request/status bundle between a frame source and the MVB transmit sequencer.
// The source drives the request fields and sees busy/done/err back.
interface mvb_tx_sequencer_if #(
    parameter int DATA_W = 64
) ();
    logic              tx_start;
    logic              tx_master;
    logic [1:0]        tx_len;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;
    logic              tx_done;
    logic              tx_err;

    modport master (
        output tx_start, tx_master, tx_len, tx_data,
        input  tx_busy, tx_done, tx_err
    );

    modport slave (
        input  tx_start, tx_master, tx_len, tx_data,
        output tx_busy, tx_done, tx_err
    );
endinterface

// File: rtl/mvb_tx_sequencer.sv
// MVB transmit frame sequencer: start delimiter via the external generator,
// Manchester payload and check byte from a local shifter, then the end delimiter.
module mvb_tx_sequencer #(
    parameter int DATA_W         = 64,
    parameter int START_SEND_CYC = 19,
    parameter int END_SEND_CYC   = 4
) (
    input  logic                clk_3M,
    input  logic                reset,
    mvb_tx_sequencer_if.slave   tx,
    input  logic                delimiter_in,
    output logic                send_delimiter,
    output logic [1:0]          delimiter_format,
    output logic                line_out,
    output logic                line_en
);
    typedef enum logic [2:0] {IDLE, SDELIM, DATA, CRC, EDELIM} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  phase_reg, phase_next;
    logic [7:0]  hb_reg, hb_next;
    logic [7:0]  last_hb_reg, last_hb_next;
    logic [63:0] shift_reg, shift_next;
    logic [6:0]  crc_reg, crc_next;
    logic        par_reg, par_next;
    logic [1:0]  fmt_reg, fmt_next;
    logic        line_out_reg, line_out_next;
    logic        line_en_reg, line_en_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;

    logic [DATA_W-1:0] data_in;
    logic              cur_bit;
    logic              crc_fb;
    logic [6:0]        crc_step;
    logic [7:0]        check_byte;

    assign data_in    = tx.tx_data;
    assign cur_bit    = shift_reg[63];
    assign crc_fb     = crc_reg[6] ^ cur_bit;
    // G(x) = x^7+x^6+x^5+x^2+1, MSB-first Galois form
    assign crc_step   = {crc_reg[5:0], 1'b0} ^ (crc_fb ? 7'h65 : 7'h00);
    assign check_byte = {~crc_step, par_reg ^ cur_bit ^ (^(~crc_step))};

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        hb_next       = hb_reg;
        last_hb_next  = last_hb_reg;
        shift_next    = shift_reg;
        crc_next      = crc_reg;
        par_next      = par_reg;
        fmt_next      = fmt_reg;
        line_out_next = 1'b0;
        line_en_next  = 1'b0;
        done_next     = 1'b0;
        err_next      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (tx.tx_start) begin
                    if (!tx.tx_master && tx.tx_len == 2'b11) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = SDELIM;
                        phase_next = 5'd0;
                        hb_next    = 8'd0;
                        crc_next   = 7'd0;
                        par_next   = 1'b0;
                        fmt_next   = tx.tx_master ? 2'b01 : 2'b10;
                        // Left-align the frame so the first bit sent is always shift_reg[63]
                        if (tx.tx_master || tx.tx_len == 2'b00) begin
                            shift_next   = {data_in[15:0], 48'd0};
                            last_hb_next = 8'd31;
                        end else if (tx.tx_len == 2'b01) begin
                            shift_next   = {data_in[31:0], 32'd0};
                            last_hb_next = 8'd63;
                        end else begin
                            shift_next   = data_in[63:0];
                            last_hb_next = 8'd127;
                        end
                    end
                end
            end
            SDELIM: begin
                phase_next = phase_reg + 5'd1;
                // Generator output lags its enable by one cycle, so phase 0 has nothing yet
                if (phase_reg != 5'd0) begin
                    line_out_next = delimiter_in;
                    line_en_next  = 1'b1;
                end
                if (phase_reg == 5'(START_SEND_CYC - 1)) begin
                    state_next = DATA;
                    phase_next = 5'd0;
                    hb_next    = 8'd0;
                end
            end
            DATA: begin
                hb_next       = hb_reg + 8'd1;
                line_out_next = hb_reg[0] ? ~cur_bit : cur_bit;
                line_en_next  = 1'b1;
                if (hb_reg[0]) begin
                    shift_next = {shift_reg[62:0], 1'b0};
                    crc_next   = crc_step;
                    par_next   = par_reg ^ cur_bit;
                end
                if (hb_reg == last_hb_reg) begin
                    state_next = CRC;
                    hb_next    = 8'd0;
                    shift_next = {check_byte, 56'd0};
                end
            end
            CRC: begin
                hb_next       = hb_reg + 8'd1;
                line_out_next = hb_reg[0] ? ~cur_bit : cur_bit;
                line_en_next  = 1'b1;
                if (hb_reg[0]) begin
                    shift_next = {shift_reg[62:0], 1'b0};
                end
                // End-delimiter request overlaps the last check half-bit
                if (hb_reg == 8'd14) begin
                    fmt_next = 2'b11;
                end
                if (hb_reg == 8'd15) begin
                    state_next = EDELIM;
                    phase_next = 5'd0;
                    hb_next    = 8'd0;
                end
            end
            EDELIM: begin
                phase_next = phase_reg + 5'd1;
                if (phase_reg <= 5'(END_SEND_CYC - 1)) begin
                    line_out_next = delimiter_in;
                    line_en_next  = 1'b1;
                end
                if (phase_reg == 5'(END_SEND_CYC)) begin
                    state_next = IDLE;
                    phase_next = 5'd0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_3M or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            phase_reg    <= 5'd0;
            hb_reg       <= 8'd0;
            last_hb_reg  <= 8'd0;
            shift_reg    <= 64'd0;
            crc_reg      <= 7'd0;
            par_reg      <= 1'b0;
            fmt_reg      <= 2'b00;
            line_out_reg <= 1'b0;
            line_en_reg  <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            hb_reg       <= hb_next;
            last_hb_reg  <= last_hb_next;
            shift_reg    <= shift_next;
            crc_reg      <= crc_next;
            par_reg      <= par_next;
            fmt_reg      <= fmt_next;
            line_out_reg <= line_out_next;
            line_en_reg  <= line_en_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    assign send_delimiter   = (state_reg == SDELIM) ||
                              (state_reg == CRC && hb_reg == 8'd15) ||
                              (state_reg == EDELIM && phase_reg < 5'(END_SEND_CYC - 1));
    assign delimiter_format = fmt_reg;
    assign line_out         = line_out_reg;
    assign line_en          = line_en_reg;
    assign tx.tx_busy       = (state_reg != IDLE);
    assign tx.tx_done       = done_reg;
    assign tx.tx_err        = err_reg;
endmodule
